peak_capture_writer: RTL and testbench
======================================

# peak_capture_writer

Acquisition-side consumer of the decimated peak-detect stream. Accepts min/max sample pairs qualified by the decimators' enable strobe and writes them as 16-bit words into a circular sample RAM. The RAM write port is driven directly. An armed pre-trigger/post-trigger state machine fills the pre-trigger region, captures the trigger position and stops after the programmed post-trigger count. It sits between the min/max decimators and the acquisition memory read by the display path.

## Interface
- ADDR_W, 12, RAM address width; the capture depth is 2^ADDR_W pairs.
- DATA_W, 8, sample width; the RAM word is 2*DATA_W.
- clk  in  1  acquisition clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  single-cycle pulse. Latches pre_len and post_len, then starts a capture.
- trig  in  1  trigger qualifier, sampled every cycle.
- pre_len  in  ADDR_W  number of pairs that must be written before a trigger is accepted.
- post_len  in  ADDR_W  number of pairs to write starting from the trigger.
- din_min  in  DATA_W  minimum sample from the min decimator.
- din_max  in  DATA_W  maximum sample from the max decimator.
- clken_in  in  1  pair-valid strobe. din_min and din_max are valid on the same cycle.
- wr_en  out  1  RAM write enable.
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  2*DATA_W  RAM write data, {max, min}.
- busy  out  1  high in PRE, WAIT_TRIG and POST.
- done  out  1  high in DONE.
- trig_addr  out  ADDR_W  address of the trigger pair.
- rd_start  out  ADDR_W  address of the oldest valid pair, equal to trig_addr - pre_len mod 2^ADDR_W.

## Operation
- States and transitions:
  - IDLE: arm → PRE.
  - PRE: pre_cnt == pre_len → WAIT_TRIG.
  - WAIT_TRIG: trig → POST.
  - POST: post_cnt == post_len → DONE.
  - DONE: arm → PRE.
- rst forces IDLE from any state. All outputs go to 0, and ptr, pre_cnt and post_cnt are cleared.
- arm in any state:
  - ptr, pre_cnt and post_cnt are cleared.
  - Lengths are latched.
  - The state becomes PRE; a capture in progress is abandoned.
  - arm has priority over trig and over every other transition on the same cycle.
- pre_len = 0: PRE exits to WAIT_TRIG on the cycle after arm.
- Writes:
  - In PRE, WAIT_TRIG and POST, each clken_in writes {din_max, din_min} at ptr.
  - ptr then increments modulo 2^ADDR_W. Wrap-around is silent; pre-trigger data is overwritten freely.
  - No writes occur in IDLE or DONE.
- pre_cnt counts pairs written in PRE and saturates at pre_len. trig in PRE is ignored.
- Trigger acceptance, at cycle t in WAIT_TRIG with trig = 1:
  - trig_addr and the rd_start computation are captured from ptr at t.
  - If clken_in is also high at t, that pair is written at ptr and counts as post pair 1.
- post_cnt counts pairs written in POST, including the pair that coincides with the trigger.
  - DONE is entered on the cycle after the write that makes post_cnt == post_len.
  - post_len = 0: POST exits to DONE on the next cycle with no further writes.
- A pre_len + post_len > 2^ADDR_W setting is legal; the oldest pre-trigger pairs are overwritten, and rd_start still follows its definition.
- trig_addr and rd_start hold their value until the next arm or rst. They read 0 before the first trigger.

## Timing
- All outputs are registered.
- wr_en, wr_addr and wr_data are asserted exactly one cycle after clken_in, for one cycle per pair.
- Back-to-back clken_in, as with n = 1 decimation, produces one write per cycle without loss.
- busy rises one cycle after arm.
- done rises one cycle after the last post write is presented (wr_en high). It stays high until arm or rst.
- trig_addr and rd_start are valid one cycle after the accepted trig.

## Structure
- Shared package: state encoding enum (IDLE, PRE, WAIT_TRIG, POST, DONE) and a localparam for the depth, 2^ADDR_W.
- Natural sub-module: peak_capture_ctrl (FSM plus the pre and post counters). The top level holds the pointer and the write-port registers.

## Test plan
- Reset recovery: rst during POST at ptr = 100 → next cycle IDLE; all outputs 0; clken_in afterwards produces no wr_en.
- Basic capture:
  - Stimulus: ADDR_W = 4, pre_len = 3, post_len = 4, clken_in every cycle, trig asserted after 5 pairs.
  - Response: trig_addr = 5, rd_start = 2, last write at address 8, done high 1 cycle later, exactly 9 writes in total.
- Ignored early trigger: trig held high from arm with pre_len = 2 → trigger accepted only in WAIT_TRIG, so trig_addr = 2.
- Wrap-around: ADDR_W = 4, pre_len = 10, trigger at ptr = 14, post_len = 6 → writes wrap through 15 → 0; last write at address 3; rd_start = 4.
- Coincident events:
  - arm and trig on the same cycle in WAIT_TRIG → restart, with PRE, ptr = 0 and no trigger captured.
  - post_len = 0 → done one cycle after the trigger with no post writes.
- Sparse strobes: clken_in every 7th cycle, din_min = 0x12, din_max = 0xE0 → wr_data = 0xE012 exactly one cycle after each strobe; done timing follows the strobe count, not the cycle count.

Source files
------------

// File: rtl/peak_capture_writer_pkg.sv
// Shared types for the peak-detect capture writer: FSM state encoding and
// default capture depth.
package peak_capture_writer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_TRIG,
    POST,
    DONE
  } cap_state_t;

  localparam int unsigned DEFAULT_ADDR_W = 12;
  localparam int unsigned DEPTH          = 1 << DEFAULT_ADDR_W;

endpackage

// File: rtl/peak_capture_ctrl.sv
// Capture sequencer: pre/post-trigger FSM with its pair counters and the
// latched capture lengths. Produces the per-cycle write and trigger strobes.
module peak_capture_ctrl
  import peak_capture_writer_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              trig,
  input  logic              clken_in,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic [ADDR_W-1:0] post_len,
  output logic              wr_req,
  output logic              trig_hit,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pre_len_q
);

  cap_state_t        state, state_nxt;
  logic [ADDR_W-1:0] post_len_q;
  logic [ADDR_W-1:0] pre_cnt, pre_cnt_nxt;
  logic [ADDR_W-1:0] post_cnt;

  // busy/done are registered from the next state so they track state exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == PRE) || (state_nxt == WAIT_TRIG) || (state_nxt == POST);
      done  <= (state_nxt == DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    if (arm) begin
      state_nxt = PRE;
    end else begin
      unique case (state)
        IDLE:      state_nxt = IDLE;
        PRE:       if (pre_cnt_nxt == pre_len_q) state_nxt = WAIT_TRIG;
        WAIT_TRIG: if (trig) state_nxt = (post_len_q == '0) ? DONE : POST;
        POST:      if (post_cnt == post_len_q) state_nxt = DONE;
        DONE:      state_nxt = DONE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    wr_req   = 1'b0;
    trig_hit = 1'b0;
    if (!arm) begin
      unique case (state)
        PRE:       wr_req = clken_in;
        WAIT_TRIG: begin
          trig_hit = trig;
          wr_req   = clken_in && (!trig || (post_len_q != '0));
        end
        POST:      wr_req = clken_in && (post_cnt != post_len_q);
        default:   wr_req = 1'b0;
      endcase
    end
  end

  always_comb begin
    pre_cnt_nxt = pre_cnt;
    if ((state == PRE) && wr_req && (pre_cnt != pre_len_q))
      pre_cnt_nxt = pre_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || arm) begin
      pre_cnt  <= '0;
      post_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt_nxt;
      if (trig_hit)
        post_cnt <= ADDR_W'(wr_req);
      else if ((state == POST) && wr_req)
        post_cnt <= post_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_len_q  <= '0;
      post_len_q <= '0;
    end else if (arm) begin
      pre_len_q  <= pre_len;
      post_len_q <= post_len;
    end
  end

endmodule

// File: rtl/peak_capture_writer.sv
// Writes decimated {max,min} pairs into a circular sample RAM under control of
// the pre/post-trigger sequencer; holds the write pointer and trigger markers.
module peak_capture_writer
  import peak_capture_writer_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                trig,
  input  logic [ADDR_W-1:0]   pre_len,
  input  logic [ADDR_W-1:0]   post_len,
  input  logic [DATA_W-1:0]   din_min,
  input  logic [DATA_W-1:0]   din_max,
  input  logic                clken_in,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [2*DATA_W-1:0] wr_data,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   trig_addr,
  output logic [ADDR_W-1:0]   rd_start
);

  logic              wr_req;
  logic              trig_hit;
  logic [ADDR_W-1:0] pre_len_q;
  logic [ADDR_W-1:0] ptr;

  peak_capture_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .arm       (arm),
    .trig      (trig),
    .clken_in  (clken_in),
    .pre_len   (pre_len),
    .post_len  (post_len),
    .wr_req    (wr_req),
    .trig_hit  (trig_hit),
    .busy      (busy),
    .done      (done),
    .pre_len_q (pre_len_q)
  );

  // Pointer wraps silently; older pre-trigger pairs are simply overwritten
  always_ff @(posedge clk) begin
    if (rst || arm)
      ptr <= '0;
    else if (wr_req)
      ptr <= ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= wr_req;
      if (wr_req) begin
        wr_addr <= ptr;
        wr_data <= {din_max, din_min};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || arm) begin
      trig_addr <= '0;
      rd_start  <= '0;
    end else if (trig_hit) begin
      trig_addr <= ptr;
      rd_start  <= ptr - pre_len_q;
    end
  end

endmodule

// File: tb/tb_peak_capture_writer.sv
// Directed bench for peak_capture_writer with a capture-level reference model
// compared every cycle, plus hand-computed pins for each scenario.
module tb_peak_capture_writer;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int D  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic          trig = 1'b0;
  logic          clken_in = 1'b0;
  logic [AW-1:0] pre_len = '0;
  logic [AW-1:0] post_len = '0;
  logic [DW-1:0] din_min = '0;
  logic [DW-1:0] din_max = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_addr;
  logic [AW-1:0] rd_start;

  peak_capture_writer #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arm       (arm),
    .trig      (trig),
    .pre_len   (pre_len),
    .post_len  (post_len),
    .din_min   (din_min),
    .din_max   (din_max),
    .clken_in  (clken_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .trig_addr (trig_addr),
    .rd_start  (rd_start)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_wr = 0;
  int last_addr = 0;
  int done_at;
  int last_wr_at;

  // Capture-level model: pairs written since arm, trigger seen, post pairs.
  bit m_active = 0, m_ready = 0, m_trig = 0, m_done = 0;
  int m_pl = 0, m_ql = 0, m_ptr = 0, m_written = 0, m_post = 0;
  bit e_wr = 0;
  int e_addr = 0, e_data = 0, e_tad = 0, e_rds = 0;

  function automatic void model_step();
    bit wr;
    e_wr = 0;
    if (rst) begin
      m_active = 0; m_ready = 0; m_trig = 0; m_done = 0;
      m_pl = 0; m_ql = 0; m_ptr = 0; m_written = 0; m_post = 0;
      e_tad = 0; e_rds = 0;
    end else if (arm) begin
      m_pl = int'(pre_len); m_ql = int'(post_len);
      m_active = 1; m_done = 0; m_ready = 0; m_trig = 0;
      m_ptr = 0; m_written = 0; m_post = 0;
      e_tad = 0; e_rds = 0;
    end else if (m_active) begin
      wr = clken_in;
      if (!m_trig) begin
        if (m_ready && trig) begin
          m_trig = 1;
          e_tad  = m_ptr;
          e_rds  = (((m_ptr - m_pl) % D) + D) % D;
          if (m_ql == 0) begin
            wr = 0; m_active = 0; m_done = 1;
          end
        end
      end else if (m_post >= m_ql) begin
        wr = 0; m_active = 0; m_done = 1;
      end
      if (wr) begin
        e_wr = 1;
        e_addr = m_ptr;
        e_data = int'({din_max, din_min});
        m_ptr = (m_ptr + 1) % D;
        m_written++;
        if (m_trig) m_post++;
      end
      if (!m_trig && m_written >= m_pl) m_ready = 1;
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic cmp_cycle();
    chk("wr_en", int'(wr_en), int'(e_wr));
    if (e_wr) begin
      chk("wr_addr", int'(wr_addr), e_addr);
      chk("wr_data", int'(wr_data), e_data);
    end
    chk("busy", int'(busy), int'(m_active));
    chk("done", int'(done), int'(m_done));
    chk("trig_addr", int'(trig_addr), e_tad);
    chk("rd_start", int'(rd_start), e_rds);
    if (wr_en) begin
      n_wr++;
      last_addr = int'(wr_addr);
    end
  endtask

  task automatic cyc(input bit a, input bit t, input bit c, input logic [7:0] mn, input logic [7:0] mx);
    arm = a; trig = t; clken_in = c; din_min = mn; din_max = mx;
    model_step();
    @(posedge clk);
    #1;
    cmp_cycle();
  endtask

  task automatic do_arm(input int pl, input int ql, input bit t);
    pre_len = AW'(pl);
    post_len = AW'(ql);
    cyc(1, t, 0, 8'h00, 8'h00);
    n_wr = 0;
    done_at = -1;
    last_wr_at = -1;
  endtask

  initial begin
    rst = 1;
    cyc(0, 0, 1, 8'h11, 8'h22);
    cyc(0, 0, 1, 8'h33, 8'h44);
    rst = 0;
    chk("reset_busy", int'(busy), 0);
    chk("reset_wr_en", int'(wr_en), 0);

    // Basic capture
    do_arm(3, 4, 0);
    for (int i = 1; i <= 14; i++) begin
      cyc(0, i == 6, 1, 8'(i * 3), 8'(255 - i));
      if (wr_en) last_wr_at = i;
      if (done && done_at < 0) done_at = i;
    end
    chk("basic_trig_addr", int'(trig_addr), 5);
    chk("basic_rd_start", int'(rd_start), 2);
    chk("basic_nwr", n_wr, 9);
    chk("basic_last_addr", last_addr, 8);
    chk("basic_last_wr_at", last_wr_at, 9);
    chk("basic_done_at", done_at, 10);

    // Early trigger held from arm
    do_arm(2, 2, 1);
    for (int i = 1; i <= 8; i++) cyc(0, 1, 1, 8'(i), 8'(i + 100));
    chk("early_trig_addr", int'(trig_addr), 2);
    chk("early_rd_start", int'(rd_start), 0);
    chk("early_nwr", n_wr, 4);

    // Wrap-around
    do_arm(10, 6, 0);
    for (int i = 1; i <= 24; i++) cyc(0, i == 15, 1, 8'(i), 8'(i ^ 8'h5A));
    chk("wrap_trig_addr", int'(trig_addr), 14);
    chk("wrap_rd_start", int'(rd_start), 4);
    chk("wrap_last_addr", last_addr, 3);
    chk("wrap_nwr", n_wr, 20);

    // arm and trig together in WAIT_TRIG restart the capture
    do_arm(1, 3, 0);
    for (int i = 1; i <= 4; i++) cyc(0, 0, 1, 8'(i), 8'(i));
    do_arm(2, 2, 1);
    chk("rearm_busy", int'(busy), 1);
    chk("rearm_trig_addr", int'(trig_addr), 0);
    cyc(0, 0, 1, 8'h01, 8'h02);
    chk("rearm_first_addr", int'(wr_addr), 0);
    for (int i = 1; i <= 10; i++) cyc(0, i == 5, 1, 8'(i), 8'(i * 7));

    // post_len = 0
    do_arm(1, 0, 0);
    cyc(0, 0, 1, 8'h05, 8'h06);
    cyc(0, 1, 1, 8'h07, 8'h08);
    chk("post0_done", int'(done), 1);
    chk("post0_wr_en", int'(wr_en), 0);
    chk("post0_trig_addr", int'(trig_addr), 1);
    chk("post0_busy", int'(busy), 0);
    for (int i = 1; i <= 3; i++) cyc(0, 0, 1, 8'(i), 8'(i));

    // Sparse strobes
    do_arm(2, 2, 0);
    for (int i = 1; i <= 35; i++) begin
      cyc(0, i == 15, (i % 7) == 0, 8'h12, 8'hE0);
      if ((i % 7) == 0 && i <= 28)
        chk("sparse_wr", int'({wr_en, wr_data}), 32'h1E012);
      if (done && done_at < 0) done_at = i;
    end
    chk("sparse_trig_addr", int'(trig_addr), 2);
    chk("sparse_nwr", n_wr, 4);
    chk("sparse_done_at", done_at, 29);

    // Reset during POST
    do_arm(1, 8, 0);
    for (int i = 1; i <= 6; i++) cyc(0, i == 3, 1, 8'(i), 8'(i));
    chk("pre_reset_busy", int'(busy), 1);
    rst = 1;
    cyc(0, 0, 1, 8'h99, 8'h98);
    rst = 0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_trig_addr", int'(trig_addr), 0);
    n_wr = 0;
    for (int i = 1; i <= 4; i++) cyc(0, 0, 1, 8'(i), 8'(i));
    chk("idle_no_writes", n_wr, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
